// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ZERO      = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and allocation bus of the multi-port register file.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_i;
    logic [NRD*XLEN-1:0] rs_data_o;
    logic [NRD-1:0]      rs_busy_o;
    logic [NWR-1:0]      wen_i;
    logic [NWR*AW-1:0]   rd_i;
    logic [NWR*XLEN-1:0] rd_data_i;
    logic                alloc_en_i;
    logic [AW-1:0]       alloc_rd_i;
    logic                alloc_ok_o;

    modport master (
        output rs_i, wen_i, rd_i, rd_data_i, alloc_en_i, alloc_rd_i,
        input  rs_data_o, rs_busy_o, alloc_ok_o
    );

    modport slave (
        input  rs_i, wen_i, rd_i, rd_data_i, alloc_en_i, alloc_rd_i,
        output rs_data_o, rs_busy_o, alloc_ok_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits used for issue-hazard checks.
// Allocation sets a bit, a writeback clears it; allocation wins on a tie.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             alloc_en_i,
    input  logic [AW-1:0]    alloc_rd_i,
    input  logic [NREGS-1:0] clr_mask_i,
    output logic [NREGS-1:0] busy_o,
    output logic             alloc_ok_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Accept an allocation when running and the target is free (x0 always accepted).
    always_comb begin
        alloc_ok_o = run_i & alloc_en_i &
                     ((alloc_rd_i == AW'(REG_ZERO)) | ~busy_q[alloc_rd_i]);
    end

    // Clear on writeback first, then apply allocation so it takes priority.
    always_comb begin
        busy_d = busy_q & ~clr_mask_i;
        if (alloc_ok_o && (alloc_rd_i != AW'(REG_ZERO))) begin
            busy_d[alloc_rd_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, a post-reset
// clearing sweep and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_done_o,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NREGS);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] wr_mask;
    logic [NREGS-1:0] busy;
    logic             run;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    wa;

    assign run         = (state_q == RUN);
    assign init_done_o = init_done_q;

    // FSM and sweep counter registers; the sweep restarts at register 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state: advance the sweep and leave INIT after the last register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // Storage update: sweep clears in INIT, ports write in RUN (later port wins).
    always_comb begin
        regs_d  = regs_q;
        wr_mask = '0;
        wa      = '0;
        if (state_q == INIT) begin
            regs_d[cnt_q] = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                wa = bus.rd_i[j*AW +: AW];
                if (bus.wen_i[j] && (wa != AW'(REG_ZERO))) begin
                    regs_d[wa]  = bus.rd_data_i[j*XLEN +: XLEN];
                    wr_mask[wa] = 1'b1;
                end
            end
        end
    end

    // Register array; contents are left alone in the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .alloc_en_i (bus.alloc_en_i),
        .alloc_rd_i (bus.alloc_rd_i),
        .clr_mask_i (wr_mask),
        .busy_o     (busy),
        .alloc_ok_o (bus.alloc_ok_o)
    );

    // Read muxes: zero in INIT or for x0, otherwise stored value and busy bit.
    always_comb begin
        bus.rs_data_o = '0;
        bus.rs_busy_o = '0;
        ra            = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.rs_i[k*AW +: AW];
            if (run && (ra != AW'(REG_ZERO))) begin
                bus.rs_data_o[k*XLEN +: XLEN] = regs_q[ra];
                bus.rs_busy_o[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wen_i[j] && (bus.rd_i[j*AW +: AW] == ra)) begin
                        bus.rs_data_o[k*XLEN +: XLEN] = bus.rd_data_i[j*XLEN +: XLEN];
                        bus.rs_busy_o[k]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read / 2 write ports, 32 x 32-bit).
module tb_regfile_mp;

    logic clk;
    logic rst;
    logic init_done;

    int checks = 0;
    int errors = 0;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done_o (init_done),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wen0, wen1;
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        logic [4:0]  rs0, rs1;
        logic [31:0] exp0, exp1;
        logic [31:0] byp0, byp1;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w0, input logic w1, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1);
        bus.wen_i     = {w1, w0};
        bus.rd_i      = {a1, a0};
        bus.rd_data_i = {d1, d0};
        bus.rs_i      = {r1, r0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!init_done && n < 100);
    endtask

    // Pop the oldest expectation and compare both read ports against it.
    task automatic compare_reads();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_p0"}, bus.rs_data_o[31:0], e.e0);
            check({e.name, "_p1"}, bus.rs_data_o[63:32], e.e1);
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int r = 0; r < 32; r += 2) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'(r), 5'(r + 1));
            sb_q.push_back('{nm, 32'd0, 32'd0});
            #1;
            compare_reads();
            check({nm, "_busy"}, {30'd0, bus.rs_busy_o}, 32'd0);
        end
    endtask

    vec_t vecs[10];
    int   n;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd5,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h22222222};
        vecs[3] = '{1'b1, 1'b0, 5'd3,  5'd0,  32'h00000001, 32'h0,        5'd7,  5'd0,  32'h22222222, 32'h0,        32'h22222222, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  5'd0,  32'h00001234, 32'h0,        5'd3,  5'd3,  32'h00000001, 32'h00000001, 32'h00001234, 32'h00001234};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  5'd7,  32'h00001234, 32'h22222222, 32'h00001234, 32'h22222222};
        vecs[6] = '{1'b1, 1'b1, 5'd10, 5'd10, 32'h0000000A, 32'h0000000B, 5'd10, 5'd5,  32'h0,        32'hDEADBEEF, 32'h0000000B, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        5'd10, 5'd0,  32'h0000000B, 32'h0,        32'h0000000B, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h80000000, 5'd31, 5'd1,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h80000000};
        vecs[9] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        5'd1,  5'd31, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        rst            = 1'b1;
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd4;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd4, 5'd0);

        // Reset state
        tick();
        tick();
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_alloc_ok", {31'd0, bus.alloc_ok_o}, 32'd0);
        check("rst_busy", {30'd0, bus.rs_busy_o}, 32'd0);
        bus.alloc_en_i = 1'b0;
        rst = 1'b0;
        wait_init(n);
        check("sweep1_len", n, 32'd31);

        // Fill every register with garbage
        for (int i = 1; i < 32; i += 2) begin
            drive(1'b1, (i + 1) < 32, 5'(i), 5'(i + 1), 32'hA5A50000 | i, 32'hA5A50000 | (i + 1), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd17, 5'd5);
        #1;
        check("garbage_x17", bus.rs_data_o[31:0], 32'hA5A50011);
        check("garbage_x5", bus.rs_data_o[63:32], 32'hA5A50005);

        // Reset pulse with write and alloc attempts during the sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 5'd0, 32'h00000BAD, 32'd0, 5'd5, 5'd17);
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd6;
        #1;
        check("init_done_low", {31'd0, init_done}, 32'd0);
        check("init_rs0_zero", bus.rs_data_o[31:0], 32'd0);
        check("init_rs1_zero", bus.rs_data_o[63:32], 32'd0);
        check("init_alloc_ok", {31'd0, bus.alloc_ok_o}, 32'd0);
        wait_init(n);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        bus.alloc_en_i = 1'b0;
        check("sweep2_len", n, 32'd31);
        #1;
        check_all_zero("swept");

        // Table-driven read/write vectors
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wen0, vecs[i].wen1, vecs[i].rd0, vecs[i].rd1,
                  vecs[i].d0, vecs[i].d1, vecs[i].rs0, vecs[i].rs1);
`ifdef REGFILE_BYPASS_EN
            sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].byp0, vecs[i].byp1});
`else
            sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1});
`endif
            #2;
            compare_reads();
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);

        // Scoreboard: allocate x9, then a second allocation is refused
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd9;
        #1;
        check("alloc9_ok", {31'd0, bus.alloc_ok_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        check("busy9_set", {31'd0, bus.rs_busy_o[0]}, 32'd1);
        check("alloc9_again", {31'd0, bus.alloc_ok_o}, 32'd0);
        tick();
        bus.alloc_en_i = 1'b0;

        // Writeback to x9 clears busy
        drive(1'b1, 1'b0, 5'd9, 5'd0, 32'h00000099, 32'd0, 5'd9, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("busy9_wb_cycle", {31'd0, bus.rs_busy_o[0]}, 32'd0);
`else
        check("busy9_wb_cycle", {31'd0, bus.rs_busy_o[0]}, 32'd1);
`endif
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        #1;
        check("busy9_clear", {31'd0, bus.rs_busy_o[0]}, 32'd0);
        check("x9_data", bus.rs_data_o[31:0], 32'h00000099);

        // Simultaneous alloc and writeback to x12: alloc wins
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd12;
        drive(1'b0, 1'b1, 5'd0, 5'd12, 32'd0, 32'h00000012, 5'd0, 5'd12);
        #1;
        check("alloc12_ok", {31'd0, bus.alloc_ok_o}, 32'd1);
        tick();
        bus.alloc_en_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd12);
        #1;
        check("busy12_set", {31'd0, bus.rs_busy_o[1]}, 32'd1);
        check("x12_data", bus.rs_data_o[63:32], 32'h00000012);

        // x0 allocation accepted but never busy
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd0;
        #1;
        check("alloc0_ok", {31'd0, bus.alloc_ok_o}, 32'd1);
        tick();
        check("busy0", {31'd0, bus.rs_busy_o[0]}, 32'd0);
        bus.alloc_rd_i = 5'd12;
        #1;
        check("alloc12_refused", {31'd0, bus.alloc_ok_o}, 32'd0);
        bus.alloc_en_i = 1'b0;

        // Reset mid-sweep restarts the full sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_done", {31'd0, init_done}, 32'd0);
        wait_init(n);
        check("sweep3_len", n, 32'd31);
        #1;
        check_all_zero("mid_swept");
        bus.alloc_en_i = 1'b1;
        bus.alloc_rd_i = 5'd12;
        #1;
        check("alloc12_after_rst", {31'd0, bus.alloc_ok_o}, 32'd1);
        bus.alloc_en_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
